serial_to_parallel: RTL

UART-style serial receiver. It is the receive-side counterpart of the parallel_to_serial transmitter and shares its baud-rate codes, parity-enable convention and WIDTH from parallel_to_serial_params_pkg. It deserialises start / WIDTH data bits (LSB first) / optional even parity / stop frames into parallel words. Received words are presented on a valid/ready output with parity, framing and overrun status.

---
 rtl/serial_to_parallel.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: UART-style receiver.
// Frames are start / WIDTH data bits (LSB first) / optional even parity / stop.
// The line is synchronised, sampled mid-bit from the detected start edge, and
// completed words are offered on a valid/ready output with error status.
module serial_to_parallel #(
    parameter int WIDTH       = 8,
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic [1:0]       baud_sel,
    input  logic             parity_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             busy
);

    // Clocks per bit for each baud code (00=9600 .. 11=115200), truncated.
    localparam int DIV_9600   = CLK_FREQ_HZ / 9600;
    localparam int DIV_19200  = CLK_FREQ_HZ / 19200;
    localparam int DIV_38400  = CLK_FREQ_HZ / 38400;
    localparam int DIV_115200 = CLK_FREQ_HZ / 115200;

    // The slowest rate has the largest period, so this width covers every code.
    localparam int CNT_W = $clog2(DIV_9600 + 1);
    localparam int IDX_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    function automatic logic [CNT_W-1:0] div_of(input logic [1:0] sel);
        unique case (sel)
            2'b00:   div_of = CNT_W'(DIV_9600);
            2'b01:   div_of = CNT_W'(DIV_19200);
            2'b10:   div_of = CNT_W'(DIV_38400);
            default: div_of = CNT_W'(DIV_115200);
        endcase
    endfunction

    logic             sync1;
    logic             sin_s;
    logic             sin_prev;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_r;
    logic             par_en_r;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] shift_reg;
    logic             par_acc;
    logic             par_err_r;
    logic             deliver;

    logic [CNT_W-1:0] half_m1;
    logic [CNT_W-1:0] div_m1;
    logic             tick_half;
    logic             tick_full;

    // Sample points: mid start bit, then one full bit period apart.
    assign half_m1   = (div_r >> 1) - CNT_W'(1);
    assign div_m1    = div_r - CNT_W'(1);
    assign tick_half = (cnt == half_m1);
    assign tick_full = (cnt == div_m1);

    // Two-flop synchroniser plus one delay stage for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments make every flop capture the pre-edge
        // value, which is what turns these three lines into a shift chain.
        if (!rst_n) begin
            // NOTE: idle-high reset values keep reset release from looking
            // like a falling start edge.
            sync1    <= 1'b1;
            sin_s    <= 1'b1;
            sin_prev <= 1'b1;
        end else begin
            sync1    <= serial_in;
            sin_s    <= sync1;
            sin_prev <= sin_s;
        end
    end

    // Receive FSM: bit timing, shifting, parity, stop check and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            div_r     <= div_of(2'b00);
            par_en_r  <= 1'b0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_acc   <= 1'b0;
            par_err_r <= 1'b0;
            deliver   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            deliver   <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= cnt + CNT_W'(1);
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!sin_s && sin_prev) begin
                        div_r     <= div_of(baud_sel);
                        par_en_r  <= parity_en;
                        bit_idx   <= '0;
                        par_acc   <= 1'b0;
                        par_err_r <= 1'b0;
                        state     <= START;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (tick_half) begin
                        cnt <= '0;
                        if (sin_s) begin
                            // Line high at mid start bit: a glitch, not a frame.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick_full) begin
                        cnt       <= '0;
                        shift_reg <= {sin_s, shift_reg[WIDTH-1:1]};
                        par_acc   <= par_acc ^ sin_s;
                        if (bit_idx == IDX_W'(WIDTH - 1)) begin
                            state <= par_en_r ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick_full) begin
                        cnt       <= '0;
                        par_err_r <= par_acc ^ sin_s;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (tick_full) begin
                        cnt <= '0;
                        if (sin_s) begin
                            // Good frame: hand off and rearm mid stop bit.
                            deliver <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (sin_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: acceptance frees the slot before the overrun check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (deliver && (!data_valid || data_ready)) begin
                data_out   <= shift_reg;
                parity_err <= par_err_r;
                data_valid <= 1'b1;
            end else begin
                if (deliver) begin
                    overrun_err <= 1'b1;
                end
                if (data_valid && data_ready) begin
                    data_valid <= 1'b0;
                end
            end
        end
    end

endmodule
